// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit turning one load/store into a single data-memory bus transaction
//   clk, rst            clock and asynchronous active-high reset
//   ex_*                EX/MEM instruction fields (valid, read/write, funct3, address, store data)
//   dmem_*              registered data-memory bus request, acknowledge and read data
//   load_data           extended load result for the MEM/WB register
//   lsu_stall           freeze for PC, IF/ID, ID/EX and EX/MEM
//   lsu_fault/lsu_done  completion pulse and its fault code (00 ok, 01 misaligned, 10 timeout, 11 illegal)
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [63:0] ex_addr,
    input  logic [63:0] ex_store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic [63:0] load_data,
    output logic        lsu_stall,
    output logic [1:0]  lsu_fault,
    output logic        lsu_done
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic [2:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [63:0] load_q, load_d;
    logic [1:0]  fault_q, fault_d;
    logic        done_q, done_d;
    logic        start, illegal, misaligned;
    logic [7:0]  base_mask;
    logic [63:0] raw, ext;
    assign start      = ex_valid & (ex_mem_read | ex_mem_write);
    assign illegal    = (ex_mem_read & ex_mem_write) | (ex_mem_read & (ex_funct3 == 3'b111)) | (ex_mem_write & ex_funct3[2]);
    assign misaligned = ex_funct3[1:0] == 2'd1 ? ex_addr[0] :
                        ex_funct3[1:0] == 2'd2 ? |ex_addr[1:0] :
                        ex_funct3[1:0] == 2'd3 ? |ex_addr[2:0] : 1'b0;
    assign base_mask  = ex_funct3[1:0] == 2'd0 ? 8'h01 :
                        ex_funct3[1:0] == 2'd1 ? 8'h03 :
                        ex_funct3[1:0] == 2'd2 ? 8'h0F : 8'hFF;
    // funct3[2] set means unsigned, so the fill bit is forced to zero
    assign raw = dmem_rdata >> {off_q, 3'b000};
    assign ext = f3_q[1:0] == 2'd0 ? {{56{~f3_q[2] & raw[7]}},  raw[7:0]}  :
                 f3_q[1:0] == 2'd1 ? {{48{~f3_q[2] & raw[15]}}, raw[15:0]} :
                 f3_q[1:0] == 2'd2 ? {{32{~f3_q[2] & raw[31]}}, raw[31:0]} : raw;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = 1'b0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        off_d   = off_q;
        f3_d    = f3_q;
        load_d  = load_q;
        fault_d = 2'b00;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (illegal || misaligned)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    fault_d = illegal ? 2'b11 : 2'b01;
                end else if (start) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    we_d    = ex_mem_write;
                    addr_d  = {ex_addr[63:3], 3'b000};
                    wdata_d = ex_mem_write ? ex_store_data << {ex_addr[2:0], 3'b000} : '0;
                    wstrb_d = ex_mem_write ? base_mask << ex_addr[2:0] : '0;
                    off_d   = ex_addr[2:0];
                    f3_d    = ex_funct3;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    load_d  = we_q ? load_q : ext;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        fault_d = 2'b10;
                    end else begin
                        req_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            load_q  <= '0;
            fault_q <= 2'b00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            load_q  <= load_d;
            fault_q <= fault_d;
            done_q  <= done_d;
        end
    end
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_wstrb = wstrb_q;
    assign load_data  = load_q;
    assign lsu_fault  = fault_q;
    assign lsu_done   = done_q;
    // DONE keeps stall low so the held instruction leaves EX/MEM instead of re-issuing
    assign lsu_stall  = ~rst & (((state_q == IDLE) & start) | (state_q == BUSY));
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized self-checking bench for mem_stage_lsu against a behavioural model
module tb_mem_stage_lsu;
    localparam int T = 4;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [63:0] ex_addr, ex_store_data;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic [63:0] load_data;
    logic        lsu_stall;
    logic [1:0]  lsu_fault;
    logic        lsu_done;
    int          errors = 0;
    int          checks = 0;
    logic [63:0] ld_model = '0;
    mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .load_data(load_data), .lsu_stall(lsu_stall), .lsu_fault(lsu_fault), .lsu_done(lsu_done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] rd);
        int          bits;
        logic [63:0] v, m;
        bits = 8 * (1 << f3[1:0]);
        v = rd >> (8 * (a % 8));
        if (bits == 64) return v;
        m = (64'd1 << bits) - 1;
        v = v & m;
        if (!f3[2] && ((v >> (bits - 1)) & 64'd1) == 64'd1) v = v | ~m;
        return v;
    endfunction
    // starts in an IDLE cycle at posedge+1, ends at posedge+1 of the following IDLE cycle
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] sd, input logic [63:0] rdat, input int wait_n);
        int          n, nb;
        logic [1:0]  fault;
        logic [63:0] e_wdata;
        logic [7:0]  e_wstrb;
        n = 1 << f3[1:0];
        if ((rd && wr) || (rd && f3 == 3'b111) || (wr && f3 >= 3'd4)) fault = 2'b11;
        else if (a % n != 0) fault = 2'b01;
        else fault = 2'b00;
        e_wdata = wr ? sd << (8 * (a % 8)) : 64'd0;
        e_wstrb = wr ? 8'(((16'd1 << n) - 16'd1) << (a % 8)) : 8'd0;
        nb = wait_n < T ? wait_n + 1 : T;
        ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr;
        ex_funct3 = f3; ex_addr = a; ex_store_data = sd;
        #1;
        chk("stall_accept", lsu_stall, 1);
        chk("req_idle", dmem_req, 0);
        chk("done_idle", lsu_done, 0);
        if (fault == 2'b00) begin
            for (int k = 0; k < nb; k++) begin
                @(posedge clk); #1;
                dmem_ack = (k == wait_n);
                dmem_rdata = (k == wait_n) ? rdat : {$urandom, $urandom};
                #1;
                chk("busy_req", dmem_req, 1);
                chk("busy_stall", lsu_stall, 1);
                chk("busy_done", lsu_done, 0);
                chk("busy_addr", dmem_addr, a & ~64'd7);
                chk("busy_we", dmem_we, wr);
                chk("busy_wstrb", dmem_wstrb, e_wstrb);
                chk("busy_wdata", dmem_wdata, e_wdata);
                chk("busy_load", load_data, ld_model);
            end
            if (rd && wait_n < T) ld_model = ref_load(f3, a, rdat);
            if (wait_n >= T) fault = 2'b10;
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("done_pulse", lsu_done, 1);
        chk("done_fault", lsu_fault, fault);
        chk("done_req", dmem_req, 0);
        chk("done_stall", lsu_stall, 0);
        chk("done_load", load_data, ld_model);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("after_done", lsu_done, 0);
    endtask
    task automatic idle_cycle();
        ex_valid = 1'($urandom); ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        dmem_ack = 1'($urandom); dmem_rdata = {$urandom, $urandom};
        #1;
        chk("idle_stall", lsu_stall, 0);
        chk("idle_req", dmem_req, 0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("idle_done", lsu_done, 0);
        chk("idle_load", load_data, ld_model);
    endtask
    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = '0;
        ex_addr = '0; ex_store_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", lsu_stall, 0);
        chk("rst_load", load_data, 0);
        chk("rst_done", lsu_done, 0);
        chk("rst_wstrb", dmem_wstrb, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(1, 0, 3'b011, 64'h1000, 0, 64'h8877665544332211, 0);
        chk("ld_value", load_data, 64'h8877665544332211);
        run_op(1, 0, 3'b000, 64'h1005, 0, 64'h0000800000000000, 0);
        chk("lb_value", load_data, 64'hFFFFFFFFFFFFFF80);
        run_op(1, 0, 3'b100, 64'h1005, 0, 64'h0000800000000000, 1);
        chk("lbu_value", load_data, 64'h80);
        run_op(0, 1, 3'b001, 64'h2006, 64'hABCD, 0, 3);
        run_op(1, 0, 3'b010, 64'h3002, 0, 0, 0);
        run_op(1, 0, 3'b011, 64'h4000, 0, 0, 10);
        for (int i = 0; i < 300; i++) begin
            int          kind;
            logic        rd, wr;
            logic [2:0]  f3;
            logic [63:0] a;
            kind = $urandom_range(0, 19);
            rd = kind < 10 || kind == 19;
            wr = kind >= 10;
            f3 = wr && !rd && kind != 18 ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 1);
            if ($urandom_range(0, 2) == 0) idle_cycle();
            run_op(rd, wr, f3, a, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, T + 1));
        end
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_funct3 = 3'b011; ex_addr = 64'h5000;
        @(posedge clk); #1;
        chk("abort_busy_req", dmem_req, 1);
        rst = 1'b1;
        #1;
        chk("abort_req", dmem_req, 0);
        chk("abort_stall", lsu_stall, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ex_valid = 1'b0;
        ld_model = '0;
        #1;
        chk("post_rst_load", load_data, 0);
        chk("post_rst_done", lsu_done, 0);
        chk("post_rst_fault", lsu_fault, 0);
        chk("post_rst_addr", dmem_addr, 0);
        chk("post_rst_wdata", dmem_wdata, 0);
        chk("post_rst_we", dmem_we, 0);
        @(posedge clk); #1;
        chk("post_rst_nodone", lsu_done, 0);
        run_op(1, 1, 3'b011, 64'h6000, 64'h1, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage of the 5-stage RV64 pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns one load or store per instruction into a single data-memory bus transaction with byte-lane steering. It stalls the pipeline until the bus acknowledges, and delivers sign- or zero-extended load data to the MEM/WB register's memory-data input.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: maximum BUSY cycles without `dmem_ack` before a bus-error completion. Range 1..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  EX/MEM holds a live instruction.
- ex_mem_read  in  1  instruction is a load.
- ex_mem_write  in  1  instruction is a store.
- ex_funct3  in  3  access size and extension, using RISC-V load/store funct3.
- ex_addr  in  64  effective address (ALU result).
- ex_store_data  in  64  rs2 value for stores.
- dmem_req  out  1  bus request; registered.
- dmem_we  out  1  1 = write; registered.
- dmem_addr  out  64  doubleword-aligned address `{ex_addr[63:3],3'b000}`; registered.
- dmem_wdata  out  64  lane-shifted store data; registered.
- dmem_wstrb  out  8  byte enables; registered. All zero for reads.
- dmem_ack  in  1  transaction complete; `dmem_rdata` is valid in the same cycle.
- dmem_rdata  in  64  read doubleword.
- load_data  out  64  extended load result, feeding MEM/WB `memwbin_mem_data_in`; registered.
- lsu_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- lsu_fault  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal access. Valid while `lsu_done` = 1.
- lsu_done  out  1  one-cycle pulse marking the cycle the memory instruction completes.

## Operation
- States: IDLE, BUSY, DONE.
- start = `ex_valid & (ex_mem_read | ex_mem_write)`.
- Illegal access is any of:
  - `ex_mem_read & ex_mem_write` both set;
  - a load with funct3 = 3'b111;
  - a store with `funct3[2]` = 1.
- Misaligned: address bits below the access size are non-zero (H: `addr[0]`; W/WU: `addr[1:0]`; D: `addr[2:0]`).
- IDLE, start, legal and aligned: register bus outputs, clear the timeout counter, go to BUSY.
- IDLE, start, illegal or misaligned: no bus access, go directly to DONE with the fault code latched. An illegal access takes precedence over a misaligned one.
- IDLE, no start: stay in IDLE.
- BUSY with `dmem_ack`: on a load, capture the extended data into `load_data`; go to DONE with fault 00.
- BUSY without ack:
  - increment the counter;
  - when the counter reaches TIMEOUT_CYCLES, go to DONE with fault 10;
  - `load_data` is left unchanged.
- DONE: pulse `lsu_done`, then return to IDLE unconditionally. This prevents re-issue of the instruction still held in EX/MEM.
- Load extraction:
  - shift = `addr[2:0]*8`; `raw = dmem_rdata >> shift`.
  - LB/LH/LW/LD sign-extend bits 7/15/31/63 of `raw`.
  - LBU/LHU/LWU zero-extend `raw`.
- Store steering:
  - `dmem_wdata = ex_store_data << shift`.
  - `dmem_wstrb` = base mask << `addr[2:0]`, with base mask 0x01/0x03/0x0F/0xFF for SB/SH/SW/SD.
- `load_data` changes only on a load acknowledge. Otherwise it holds its value, including across stores, faults and non-memory instructions.

## Timing
- `lsu_stall` = `(IDLE & start) | BUSY`. It is combinational and low in DONE, so the pipeline advances at the end of the DONE cycle.
- Minimum latency: cycle 0 accept, cycle 1 BUSY with `dmem_req` = 1 and `dmem_ack` = 1, cycle 2 DONE. That is 2 stall cycles.
- Each extra wait cycle adds one stall cycle.
- `dmem_req` is 1 in every BUSY cycle and 0 otherwise. `dmem_addr`, `dmem_we`, `dmem_wdata` and `dmem_wstrb` are stable throughout BUSY.
- A fault path costs 1 stall cycle (cycle 0 IDLE, cycle 1 DONE).
- `dmem_ack` outside BUSY is ignored.
- Reset values: state IDLE, `dmem_req` 0, `dmem_we` 0, `dmem_addr` 0, `dmem_wdata` 0, `dmem_wstrb` 0, `load_data` 0, `lsu_fault` 00, `lsu_done` 0, counter 0.
- `lsu_stall` is forced to 0 while `rst` is high.
- Reset mid-BUSY aborts immediately: `dmem_req` drops asynchronously and no completion is reported.
- Back-to-back memory instructions: the second is accepted in the IDLE cycle following DONE.

## Test plan
- LD at 0x1000, ack on the first BUSY cycle, rdata 0x8877665544332211: `lsu_stall` high for 2 cycles, `dmem_addr` 0x1000, `load_data` 0x8877665544332211, `lsu_done` in cycle 2.
- LB at 0x1005, rdata 0x0000_8000_0000_0000 → `load_data` 0xFFFFFFFFFFFFFF80. LBU at the same address → 0x80.
- SH at 0x2006, store_data 0xABCD: `dmem_we` = 1, `dmem_wstrb` 0xC0, `dmem_wdata` 0xABCD000000000000. Hold ack off 3 cycles: stall lasts 5 cycles and the bus outputs stay stable.
- LW at 0x3002: no `dmem_req`, `lsu_fault` 01 with `lsu_done` in cycle 1, stall for 1 cycle, `load_data` unchanged.
- TIMEOUT_CYCLES = 4, load with no ack: DONE after 4 BUSY cycles, `lsu_fault` 10, `dmem_req` deasserted.
- Assert `rst` during BUSY: `dmem_req` goes to 0 without waiting for a clock edge. After release, state is IDLE and all outputs are at their reset values. Finally, `ex_mem_read` and `ex_mem_write` both high gives fault 11 with no bus request.
